// File: rtl/temperature_alarm_controller.sv
// temperature_alarm_controller
//
// Debounces the per-sample low/high abnormality flags from the temperature
// abnormality detector and drives the heater/cooler actuators, a latched
// operator alarm with acknowledge, a sticky sensor-fault flag and a
// saturating count of activations.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   sample_valid - one-cycle strobe; low_abn/high_abn carry a new sample
//   low_abn      - low-temperature abnormality flag
//   high_abn     - high-temperature abnormality flag
//   alarm_ack    - operator acknowledge, level sampled every clock
//   heater_on    - heater drive (active in ACT_LOW)
//   cooler_on    - cooler drive (active in ACT_HIGH)
//   alarm        - latched alarm
//   alarm_type   - 00 none, 01 low, 10 high, 11 sensor fault
//   sensor_fault - sticky; both flags were seen in one sample
//   event_count  - number of activations, saturating at all-ones
module temperature_alarm_controller #(
  parameter int unsigned CONFIRM_CNT = 4,
  parameter int unsigned CLEAR_CNT   = 8,
  parameter int unsigned EVT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic             low_abn,
  input  logic             high_abn,
  input  logic             alarm_ack,
  output logic             heater_on,
  output logic             cooler_on,
  output logic             alarm,
  output logic [1:0]       alarm_type,
  output logic             sensor_fault,
  output logic [EVT_W-1:0] event_count
);

  typedef enum logic [2:0] {
    StNormal,
    StPendLow,
    StPendHigh,
    StActLow,
    StActHigh
  } state_e;

  localparam logic [4:0] ConfirmLim = 5'(CONFIRM_CNT);
  localparam logic [4:0] ClearLim   = 5'(CLEAR_CNT);

  localparam logic [1:0] TypeNone  = 2'b00;
  localparam logic [1:0] TypeLow   = 2'b01;
  localparam logic [1:0] TypeHigh  = 2'b10;
  localparam logic [1:0] TypeFault = 2'b11;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             heater_q, heater_d;
  logic             cooler_q, cooler_d;
  logic             alarm_q, alarm_d;
  logic [1:0]       alarm_type_q, alarm_type_d;
  logic             fault_q, fault_d;
  logic [1:0]       act_type_q, act_type_d;  // latched low/high activation, 00 if none
  logic [EVT_W-1:0] evt_q, evt_d;

  logic       cls_l, cls_h, cls_n, cls_f;
  logic [4:0] cnt_inc;
  logic       entry_low, entry_high;

  assign cls_l   = low_abn & ~high_abn;
  assign cls_h   = high_abn & ~low_abn;
  assign cls_n   = ~low_abn & ~high_abn;
  assign cls_f   = low_abn & high_abn;
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  // Debounce state machine; only a valid sample moves it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sample_valid) begin
      unique case (state_q)
        StNormal: begin
          // A first sample counts as 1, so CONFIRM_CNT=1 activates at once.
          if (cls_l) begin
            if (5'd1 >= ConfirmLim) begin
              state_d = StActLow;
              cnt_d   = 4'd0;
            end else begin
              state_d = StPendLow;
              cnt_d   = 4'd1;
            end
          end else if (cls_h) begin
            if (5'd1 >= ConfirmLim) begin
              state_d = StActHigh;
              cnt_d   = 4'd0;
            end else begin
              state_d = StPendHigh;
              cnt_d   = 4'd1;
            end
          end
        end
        StPendLow: begin
          if (cls_l) begin
            if (cnt_inc >= ConfirmLim) begin
              state_d = StActLow;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else if (cls_h) begin
            state_d = StPendHigh;
            cnt_d   = 4'd1;
          end else begin
            state_d = StNormal;
            cnt_d   = 4'd0;
          end
        end
        StPendHigh: begin
          if (cls_h) begin
            if (cnt_inc >= ConfirmLim) begin
              state_d = StActHigh;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else if (cls_l) begin
            state_d = StPendLow;
            cnt_d   = 4'd1;
          end else begin
            state_d = StNormal;
            cnt_d   = 4'd0;
          end
        end
        StActLow: begin
          if (cls_n) begin
            if (cnt_inc >= ClearLim) begin
              state_d = StNormal;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else if (cls_h) begin
            // Opposite extreme must be re-confirmed before the cooler engages.
            state_d = StPendHigh;
            cnt_d   = 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
        end
        StActHigh: begin
          if (cls_n) begin
            if (cnt_inc >= ClearLim) begin
              state_d = StNormal;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else if (cls_l) begin
            state_d = StPendLow;
            cnt_d   = 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = StNormal;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Alarm latch, fault flag and event counter.
  always_comb begin
    entry_low  = (state_d == StActLow) && (state_q != StActLow);
    entry_high = (state_d == StActHigh) && (state_q != StActHigh);

    heater_d = (state_d == StActLow);
    cooler_d = (state_d == StActHigh);

    // Activation beats a same-cycle acknowledge.
    act_type_d = act_type_q;
    if (entry_low) begin
      act_type_d = TypeLow;
    end else if (entry_high) begin
      act_type_d = TypeHigh;
    end else if (alarm_ack) begin
      act_type_d = TypeNone;
    end

    // A same-cycle fault sample beats the acknowledge.
    fault_d = fault_q;
    if (sample_valid && cls_f) begin
      fault_d = 1'b1;
    end else if (alarm_ack) begin
      fault_d = 1'b0;
    end

    evt_d = evt_q;
    if ((entry_low || entry_high) && (evt_q != {EVT_W{1'b1}})) begin
      evt_d = evt_q + EVT_W'(1);
    end

    // A latched activation type takes precedence over the fault type.
    alarm_d      = (act_type_d != TypeNone) || fault_d;
    alarm_type_d = TypeNone;
    if (act_type_d != TypeNone) begin
      alarm_type_d = act_type_d;
    end else if (fault_d) begin
      alarm_type_d = TypeFault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StNormal;
      cnt_q        <= 4'd0;
      heater_q     <= 1'b0;
      cooler_q     <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_type_q <= TypeNone;
      fault_q      <= 1'b0;
      act_type_q   <= TypeNone;
      evt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      heater_q     <= heater_d;
      cooler_q     <= cooler_d;
      alarm_q      <= alarm_d;
      alarm_type_q <= alarm_type_d;
      fault_q      <= fault_d;
      act_type_q   <= act_type_d;
      evt_q        <= evt_d;
    end
  end

  assign heater_on    = heater_q;
  assign cooler_on    = cooler_q;
  assign alarm        = alarm_q;
  assign alarm_type   = alarm_type_q;
  assign sensor_fault = fault_q;
  assign event_count  = evt_q;

endmodule

// File: doc/temperature_alarm_controller.md
Name: temperature_alarm_controller

Overview:
Sequential stage directly downstream of the temperature abnormality detector. Consumes its per-sample low/high abnormality flags and debounces them over consecutive valid samples. Drives the heater and cooler actuators, a latched operator alarm with acknowledge, a sensor-fault flag and a saturating abnormal-event counter.

Parameters:
CONFIRM_CNT, 4, consecutive same-type abnormal samples required to activate (legal range 1..15)
CLEAR_CNT, 8, consecutive normal samples required to deactivate (legal range 1..15)
EVT_W, 8, width of event counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sample_valid  input  1  one-cycle strobe: low_abn/high_abn hold a new sample
low_abn  input  1  lowTempAbnormality from detector
high_abn  input  1  highTempAbnormality from detector
alarm_ack  input  1  operator acknowledge, level sampled each clock
heater_on  output  1  heater drive
cooler_on  output  1  cooler drive
alarm  output  1  latched alarm
alarm_type  output  2  00 none, 01 low, 10 high, 11 fault
sensor_fault  output  1  sticky: both flags seen together
event_count  output  EVT_W  number of activations, saturating

Behaviour:
- Reset (async, rst_n=0): state NORMAL, internal counter 0, all outputs 0. Registers released on the first clk edge after rst_n rises. Reset mid-debounce discards progress.
- All outputs registered. Effect of a sample is visible on the cycle after the sample_valid edge.
- State and counter advance only when sample_valid=1. Otherwise they hold. Only alarm_ack acts without a sample.
- Sample class: L = low&~high, H = high&~low, N = neither, F = both.
- Internal counter cnt is 4 bits wide and never exceeds max(CONFIRM_CNT, CLEAR_CNT).
- States: NORMAL, PEND_LOW, PEND_HIGH, ACT_LOW, ACT_HIGH.
- NORMAL:
  - L -> PEND_LOW with cnt=1. If CONFIRM_CNT=1, go directly to ACT_LOW instead.
  - H -> PEND_HIGH under the same rule.
  - N -> stay.
  - F -> stay and set sensor_fault.
- PEND_LOW:
  - L -> cnt+1. When cnt+1 = CONFIRM_CNT, go to ACT_LOW with cnt=0.
  - H -> PEND_HIGH with cnt=1.
  - N -> NORMAL with cnt=0.
  - F -> NORMAL with cnt=0, and set sensor_fault.
- PEND_HIGH: mirror of PEND_LOW with L and H swapped.
- ACT_LOW:
  - heater_on=1, cooler_on=0.
  - L -> cnt=0.
  - N -> cnt+1. When cnt+1 = CLEAR_CNT, go to NORMAL with cnt=0.
  - H -> PEND_HIGH with cnt=1. Heater drops immediately; no direct ACT_LOW -> ACT_HIGH transition.
  - F -> stay, cnt=0, set sensor_fault.
- ACT_HIGH: mirror of ACT_LOW; cooler_on=1.
- heater_on and cooler_on are never both 1.
- Entry into ACT_LOW or ACT_HIGH:
  - Set alarm=1.
  - Set alarm_type to 01 or 10.
  - Increment event_count, saturating at all-ones (no wrap).
- Alarm latch:
  - alarm and alarm_type persist after return to NORMAL until alarm_ack=1 clears them to 0/00.
  - Ack while still in an ACT state clears the latch, but the actuator stays on.
  - Ack in the same cycle as an activation: the activation wins (alarm=1).
- sensor_fault: sticky until alarm_ack.
  - If sensor_fault is set and no activation is latched, alarm=1 and alarm_type=11.
  - A later low/high activation overwrites alarm_type.
  - Ack clears sensor_fault together with the alarm, unless F arrives in the same cycle; then the fault wins.

Test Plan:
- Reset, then 4 valid L samples (CONFIRM_CNT=4) -> heater_on=1, alarm=1, alarm_type=01, event_count=1, one cycle after the 4th strobe; after only 3 L samples, heater_on=0.
- In ACT_HIGH, 7 N samples then 1 H, then 8 N -> cooler stays on through the first 7 N (counter restarts on H), drops after the 8th N of the final run; alarm stays 1 until alarm_ack pulse, then 0/00.
- Pattern L,L,H,H,H,H -> heater never on, cooler_on=1 after the 6th sample, event_count=1.
- One F sample in NORMAL -> sensor_fault=1, alarm=1, alarm_type=11, state unchanged; alarm_ack pulse -> all cleared; F together with ack -> sensor_fault remains 1.
- Drive 260 activation cycles -> event_count saturates at 255. Assert rst_n=0 asynchronously mid-PEND (between clock edges) -> outputs 0 immediately; after release, 3 L samples do not activate.
- sample_valid=0 with low_abn=1 for 20 cycles -> no state change, heater_on=0.
